// File: rtl/trace_lane_serializer_pkg.sv
// Shared constants and the default-build trace record for the trace lane serializer.
// The RTL itself is parameterised; the record type is sized for the standard 3-lane/RV64 build.
package trace_lane_serializer_pkg;

    localparam int TL_NUM_LANES = 3;
    localparam int TL_XLEN      = 64;
    localparam int TL_ILEN      = 32;
    localparam int TL_ECAUSE_W  = 5;

    // Lane index width; a single-lane build still needs a 1-bit field.
    function automatic int tl_lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TL_LANE_W = tl_lane_w(TL_NUM_LANES);

    typedef struct packed {
        logic [TL_ILEN-1:0]     insn;
        logic [TL_XLEN-1:0]     addr;
        logic                   exception;
        logic                   interrupt;
        logic [TL_ECAUSE_W-1:0] ecause;
        logic [TL_XLEN-1:0]     tval;
        logic [TL_LANE_W-1:0]   lane;
    } trace_lane_rec_t;

endpackage

// File: rtl/trace_lane_serializer_if.sv
// One-instruction-per-cycle trace record stream (valid/ready) toward the debug trace sink.
interface trace_lane_serializer_if
    import trace_lane_serializer_pkg::*;
#(
    parameter int XLEN   = TL_XLEN,
    parameter int ILEN   = TL_ILEN,
    parameter int LANE_W = TL_LANE_W
);
    logic                   out_valid;
    logic                   out_ready;
    logic [LANE_W-1:0]      out_lane;
    logic [ILEN-1:0]        out_insn;
    logic [XLEN-1:0]        out_addr;
    logic                   out_exception;
    logic                   out_interrupt;
    logic [TL_ECAUSE_W-1:0] out_ecause;
    logic [XLEN-1:0]        out_tval;
    logic                   out_last;

    modport master (
        output out_valid, out_lane, out_insn, out_addr, out_exception,
               out_interrupt, out_ecause, out_tval, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_lane, out_insn, out_addr, out_exception,
               out_interrupt, out_ecause, out_tval, out_last,
        output out_ready
    );
endinterface

// File: rtl/trace_lane_serializer_pick.sv
// Lowest-set-bit picker over the remaining-lane mask: index, one-hot and whether it is the final lane.
module trace_lane_pick #(
    parameter int NUM_LANES = 3,
    parameter int LANE_W    = 2
) (
    input  logic [NUM_LANES-1:0] mask,
    output logic [LANE_W-1:0]    idx,
    output logic [NUM_LANES-1:0] onehot,
    output logic                 is_last
);
    always_comb begin
        idx    = '0;
        onehot = mask & (~mask + NUM_LANES'(1));
        // Descending scan so the lowest set bit is written last and wins.
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) idx = LANE_W'(i);
        end
        is_last = (|mask) & ((mask & ~onehot) == '0);
    end
endmodule

// File: rtl/trace_lane_serializer.sv
// Buffers multi-lane retirement trace packets in a small FIFO and replays them one lane per cycle.
// Never back-pressures the core: packets arriving to a full FIFO are dropped and counted.
module trace_lane_serializer
    import trace_lane_serializer_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int XLEN      = 64,
    parameter int ILEN      = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic                      flush,
    input  logic [NUM_LANES-1:0]      in_lane_valid,
    input  logic [NUM_LANES*ILEN-1:0] in_insn,
    input  logic [NUM_LANES*XLEN-1:0] in_addr,
    input  logic [NUM_LANES-1:0]      in_exception,
    input  logic [NUM_LANES-1:0]      in_interrupt,
    input  logic [TL_ECAUSE_W-1:0]    in_ecause,
    input  logic [XLEN-1:0]           in_tval,
    trace_lane_serializer_if.master   tr,
    output logic                      full,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      overflow
);
    localparam int LANE_W   = tl_lane_w(NUM_LANES);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_W + 1;
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

    logic [NUM_LANES-1:0]   mask_mem_q   [DEPTH];
    logic [ILEN-1:0]        insn_mem_q   [DEPTH][NUM_LANES];
    logic [XLEN-1:0]        addr_mem_q   [DEPTH][NUM_LANES];
    logic [NUM_LANES-1:0]   exc_mem_q    [DEPTH];
    logic [NUM_LANES-1:0]   int_mem_q    [DEPTH];
    logic [TL_ECAUSE_W-1:0] ecause_mem_q [DEPTH];
    logic [XLEN-1:0]        tval_mem_q   [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic [NUM_LANES-1:0] remain_q, remain_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic                 overflow_q, overflow_d;

    logic                 out_valid, xfer, pkt_any, push, pop, drop;
    logic [PTR_W-1:0]     rd_ptr_nxt;
    logic [LANE_W-1:0]    pick_idx;
    logic [NUM_LANES-1:0] pick_onehot;
    logic                 pick_last;
    logic                 head_trap;

    trace_lane_pick #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_pick (
        .mask    (remain_q),
        .idx     (pick_idx),
        .onehot  (pick_onehot),
        .is_last (pick_last)
    );

    always_comb begin
        out_valid  = (count_q != '0);
        xfer       = out_valid & tr.out_ready;
        pkt_any    = |in_lane_valid;
        pop        = xfer & pick_last & ~flush;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push       = pkt_any & ~flush & ((count_q != DEPTH_C) | pop);
        drop       = pkt_any & ~flush & ~push;
        rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        remain_d   = remain_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            remain_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_nxt;
            if (push && !pop)      count_d = count_q + CNT_BITS'(1);
            else if (pop && !push) count_d = count_q - CNT_BITS'(1);

            // The incoming packet becomes head directly when nothing else is queued ahead of it.
            if (pop) begin
                if (count_q > CNT_BITS'(1)) remain_d = mask_mem_q[rd_ptr_nxt];
                else if (push)              remain_d = in_lane_valid;
                else                        remain_d = '0;
            end else if (push && count_q == '0) begin
                remain_d = in_lane_valid;
            end else if (xfer) begin
                remain_d = remain_q & ~pick_onehot;
            end

            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            remain_q   <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            remain_q   <= remain_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int e = 0; e < DEPTH; e++) begin
                mask_mem_q[e]   <= '0;
                exc_mem_q[e]    <= '0;
                int_mem_q[e]    <= '0;
                ecause_mem_q[e] <= '0;
                tval_mem_q[e]   <= '0;
                for (int l = 0; l < NUM_LANES; l++) begin
                    insn_mem_q[e][l] <= '0;
                    addr_mem_q[e][l] <= '0;
                end
            end
        end else if (push) begin
            mask_mem_q[wr_ptr_q]   <= in_lane_valid;
            exc_mem_q[wr_ptr_q]    <= in_exception;
            int_mem_q[wr_ptr_q]    <= in_interrupt;
            ecause_mem_q[wr_ptr_q] <= in_ecause;
            tval_mem_q[wr_ptr_q]   <= in_tval;
            for (int l = 0; l < NUM_LANES; l++) begin
                insn_mem_q[wr_ptr_q][l] <= in_insn[l*ILEN +: ILEN];
                addr_mem_q[wr_ptr_q][l] <= in_addr[l*XLEN +: XLEN];
            end
        end
    end

    // Record fields are gated by out_valid so an empty FIFO presents all-zero outputs.
    always_comb begin
        head_trap        = exc_mem_q[rd_ptr_q][pick_idx] | int_mem_q[rd_ptr_q][pick_idx];
        tr.out_valid     = out_valid;
        tr.out_lane      = out_valid ? pick_idx : '0;
        tr.out_insn      = out_valid ? insn_mem_q[rd_ptr_q][pick_idx] : '0;
        tr.out_addr      = out_valid ? addr_mem_q[rd_ptr_q][pick_idx] : '0;
        tr.out_exception = out_valid & exc_mem_q[rd_ptr_q][pick_idx];
        tr.out_interrupt = out_valid & int_mem_q[rd_ptr_q][pick_idx];
        tr.out_ecause    = (out_valid & head_trap) ? ecause_mem_q[rd_ptr_q] : '0;
        tr.out_tval      = (out_valid & head_trap) ? tval_mem_q[rd_ptr_q] : '0;
        tr.out_last      = out_valid & pick_last;
        full             = (count_q == DEPTH_C);
        drop_cnt         = drop_cnt_q;
        overflow         = overflow_q;
    end

endmodule

// File: tb/tb_trace_lane_serializer.sv
// Directed bench for trace_lane_serializer with a packet-queue reference model checked every cycle.
module tb_trace_lane_serializer;
    import trace_lane_serializer_pkg::*;

    localparam int NL    = 3;
    localparam int XL    = 64;
    localparam int IL    = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic            clk = 1'b0;
    logic            rst_l;
    logic            flush;
    logic [NL-1:0]   in_lane_valid;
    logic [NL*IL-1:0] in_insn;
    logic [NL*XL-1:0] in_addr;
    logic [NL-1:0]   in_exception;
    logic [NL-1:0]   in_interrupt;
    logic [4:0]      in_ecause;
    logic [XL-1:0]   in_tval;
    logic            full;
    logic [CNT_W-1:0] drop_cnt;
    logic            overflow;

    trace_lane_serializer_if #(.XLEN(XL), .ILEN(IL), .LANE_W(TL_LANE_W)) tr ();

    trace_lane_serializer #(
        .NUM_LANES (NL), .XLEN (XL), .ILEN (IL), .DEPTH (DEPTH), .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .flush         (flush),
        .in_lane_valid (in_lane_valid),
        .in_insn       (in_insn),
        .in_addr       (in_addr),
        .in_exception  (in_exception),
        .in_interrupt  (in_interrupt),
        .in_ecause     (in_ecause),
        .in_tval       (in_tval),
        .tr            (tr),
        .full          (full),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0]    mask;
        logic [NL*IL-1:0] insn;
        logic [NL*XL-1:0] addr;
        logic [NL-1:0]    exc;
        logic [NL-1:0]    intr;
        logic [4:0]       ec;
        logic [XL-1:0]    tval;
    } pkt_t;

    pkt_t       pq[$];
    logic [2:0] m_done;
    int         m_drop;
    logic       m_ovf;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected presented record: lowest not-yet-sent lane of the oldest queued packet.
    function automatic void model_out(output logic vld, output logic last, output trace_lane_rec_t r);
        pkt_t       h;
        logic [2:0] rem;
        int         li;
        r    = '0;
        vld  = 1'b0;
        last = 1'b0;
        if (pq.size() != 0) begin
            h    = pq[0];
            rem  = h.mask & ~m_done;
            vld  = 1'b1;
            last = ($countones(rem) == 1);
            li   = 0;
            for (int i = NL - 1; i >= 0; i--) if (rem[i]) li = i;
            r.lane      = TL_LANE_W'(li);
            r.insn      = h.insn[li*IL +: IL];
            r.addr      = h.addr[li*XL +: XL];
            r.exception = h.exc[li];
            r.interrupt = h.intr[li];
            if (r.exception || r.interrupt) begin
                r.ecause = h.ec;
                r.tval   = h.tval;
            end
        end
    endfunction

    task automatic model_step();
        logic            v, l;
        trace_lane_rec_t r;
        pkt_t            p;
        if (!rst_l) begin
            pq.delete();
            m_done = '0;
            m_drop = 0;
            m_ovf  = 1'b0;
        end else if (flush) begin
            pq.delete();
            m_done = '0;
            m_ovf  = 1'b0;
        end else begin
            model_out(v, l, r);
            if (v && tr.out_ready) begin
                if (l) begin
                    void'(pq.pop_front());
                    m_done = '0;
                end else begin
                    m_done[r.lane] = 1'b1;
                end
            end
            if (|in_lane_valid) begin
                if (pq.size() < DEPTH) begin
                    p.mask = in_lane_valid; p.insn = in_insn; p.addr = in_addr;
                    p.exc  = in_exception;  p.intr = in_interrupt;
                    p.ec   = in_ecause;     p.tval = in_tval;
                    pq.push_back(p);
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_l);
            model_step();
        end
    end

    initial begin
        logic            v, l;
        trace_lane_rec_t r;
        forever begin
            @(negedge clk);
            model_out(v, l, r);
            chk("out_valid",     64'(tr.out_valid),     64'(v));
            chk("out_lane",      64'(tr.out_lane),      64'(r.lane));
            chk("out_insn",      64'(tr.out_insn),      64'(r.insn));
            chk("out_addr",      tr.out_addr,           r.addr);
            chk("out_exception", 64'(tr.out_exception), 64'(r.exception));
            chk("out_interrupt", 64'(tr.out_interrupt), 64'(r.interrupt));
            chk("out_ecause",    64'(tr.out_ecause),    64'(r.ecause));
            chk("out_tval",      tr.out_tval,           r.tval);
            chk("out_last",      64'(tr.out_last),      64'(l));
            chk("full",          64'(full),             64'(pq.size() == DEPTH));
            chk("drop_cnt",      64'(drop_cnt),         64'(m_drop));
            chk("overflow",      64'(overflow),         64'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic [2:0] m, input logic [63:0] a0, input logic [63:0] a1,
                           input logic [63:0] a2, input logic [2:0] exc, input logic [2:0] intr,
                           input logic [4:0] ec, input logic [63:0] tv);
        in_lane_valid = m;
        in_addr       = {a2, a1, a0};
        in_insn       = {a2[31:0] ^ 32'h33, a1[31:0] ^ 32'h33, a0[31:0] ^ 32'h33};
        in_exception  = exc;
        in_interrupt  = intr;
        in_ecause     = ec;
        in_tval       = tv;
    endtask

    task automatic clr_pkt();
        set_pkt(3'b000, 64'h0, 64'h0, 64'h0, 3'b000, 3'b000, 5'd0, 64'h0);
    endtask

    initial begin
        rst_l = 1'b0;
        flush = 1'b0;
        tr.out_ready = 1'b0;
        clr_pkt();
        repeat (3) tick();
        chk("rst_valid",    64'(tr.out_valid), 64'd0);
        chk("rst_full",     64'(full),         64'd0);
        chk("rst_drop",     64'(drop_cnt),     64'd0);
        chk("rst_overflow", 64'(overflow),     64'd0);
        rst_l = 1'b1;
        tick();

        // Reset asserted with three packets queued
        for (int k = 0; k < 3; k++) begin
            set_pkt(3'b001, 64'h100 + 64'(k * 4), 64'h0, 64'h0, 3'b000, 3'b000, 5'd0, 64'h0);
            tick();
        end
        clr_pkt();
        chk("t1_pre_valid", 64'(tr.out_valid), 64'd1);
        chk("t1_pre_addr",  tr.out_addr,       64'h100);
        rst_l = 1'b0;
        #1;
        chk("t1_async_valid", 64'(tr.out_valid), 64'd0);
        chk("t1_async_addr",  tr.out_addr,       64'h0);
        chk("t1_async_insn",  64'(tr.out_insn),  64'h0);
        tick();
        rst_l = 1'b1;
        tick();
        chk("t1_post_valid", 64'(tr.out_valid), 64'd0);

        // Serialise a two-lane packet
        tr.out_ready = 1'b1;
        set_pkt(3'b101, 64'h1000, 64'h0, 64'h1008, 3'b000, 3'b000, 5'd0, 64'h0);
        tick();
        clr_pkt();
        chk("t2_lane0",  64'(tr.out_lane),  64'd0);
        chk("t2_addr0",  tr.out_addr,       64'h1000);
        chk("t2_last0",  64'(tr.out_last),  64'd0);
        tick();
        chk("t2_lane2",  64'(tr.out_lane),  64'd2);
        chk("t2_addr2",  tr.out_addr,       64'h1008);
        chk("t2_last2",  64'(tr.out_last),  64'd1);
        tick();
        chk("t2_empty",  64'(tr.out_valid), 64'd0);

        // Overflow with the sink stalled
        tr.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_pkt(3'b001, 64'h2000 + 64'(k * 4), 64'h0, 64'h0, 3'b000, 3'b000, 5'd0, 64'h0);
            tick();
        end
        clr_pkt();
        chk("t3_full",     64'(full),     64'd1);
        chk("t3_drop",     64'(drop_cnt), 64'd2);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_head",     tr.out_addr,   64'h2000);

        // Push and pop together while full
        tr.out_ready = 1'b1;
        set_pkt(3'b001, 64'h3000, 64'h0, 64'h0, 3'b000, 3'b000, 5'd0, 64'h0);
        tick();
        clr_pkt();
        chk("t4_full",  64'(full),     64'd1);
        chk("t4_drop",  64'(drop_cnt), 64'd2);
        chk("t4_head",  tr.out_addr,   64'h2004);
        tick();
        chk("t4_ord2",  tr.out_addr,   64'h2008);
        tick();
        chk("t4_ord3",  tr.out_addr,   64'h200C);
        tick();
        chk("t4_new",   tr.out_addr,   64'h3000);
        tick();
        chk("t4_empty", 64'(tr.out_valid), 64'd0);

        // Trap fields only on the trapping lane
        set_pkt(3'b011, 64'h4000, 64'h4004, 64'h0, 3'b010, 3'b000, 5'd2, 64'hDEAD);
        tick();
        clr_pkt();
        chk("t5_l0_lane",   64'(tr.out_lane),      64'd0);
        chk("t5_l0_ecause", 64'(tr.out_ecause),    64'd0);
        chk("t5_l0_tval",   tr.out_tval,           64'h0);
        chk("t5_l0_exc",    64'(tr.out_exception), 64'd0);
        set_pkt(3'b100, 64'h0, 64'h0, 64'h4100, 3'b100, 3'b100, 5'd7, 64'hBEEF);
        tick();
        clr_pkt();
        chk("t5_l1_lane",   64'(tr.out_lane),      64'd1);
        chk("t5_l1_exc",    64'(tr.out_exception), 64'd1);
        chk("t5_l1_ecause", 64'(tr.out_ecause),    64'd2);
        chk("t5_l1_tval",   tr.out_tval,           64'hDEAD);
        tick();
        chk("t5_both_exc",  64'(tr.out_exception), 64'd1);
        chk("t5_both_int",  64'(tr.out_interrupt), 64'd1);
        chk("t5_both_ec",   64'(tr.out_ecause),    64'd7);
        chk("t5_both_tval", tr.out_tval,           64'hBEEF);
        tick();
        chk("t5_empty",     64'(tr.out_valid),     64'd0);

        // Flush with drops recorded, then backpressure hold
        tr.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            set_pkt(3'b001, 64'h5000 + 64'(k * 4), 64'h0, 64'h0, 3'b000, 3'b000, 5'd0, 64'h0);
            tick();
        end
        clr_pkt();
        chk("t6_drop7", 64'(drop_cnt), 64'd7);
        tr.out_ready = 1'b1;
        tick();
        tr.out_ready = 1'b0;
        chk("t6_cnt3_full", 64'(full),   64'd0);
        chk("t6_cnt3_head", tr.out_addr, 64'h5004);
        flush = 1'b1;
        set_pkt(3'b001, 64'h6000, 64'h0, 64'h0, 3'b000, 3'b000, 5'd0, 64'h0);
        tick();
        flush = 1'b0;
        clr_pkt();
        chk("t6_fl_valid",    64'(tr.out_valid), 64'd0);
        chk("t6_fl_overflow", 64'(overflow),     64'd0);
        chk("t6_fl_drop",     64'(drop_cnt),     64'd7);
        set_pkt(3'b110, 64'h0, 64'h5108, 64'h5110, 3'b000, 3'b000, 5'd0, 64'h0);
        tick();
        clr_pkt();
        for (int i = 0; i < 5; i++) begin
            chk("t6_hold_lane", 64'(tr.out_lane), 64'd1);
            chk("t6_hold_addr", tr.out_addr,      64'h5108);
            chk("t6_hold_last", 64'(tr.out_last), 64'd0);
            tick();
        end
        tr.out_ready = 1'b1;
        tick();
        chk("t6_rel_lane", 64'(tr.out_lane), 64'd2);
        chk("t6_rel_addr", tr.out_addr,      64'h5110);
        tick();
        chk("t6_empty",    64'(tr.out_valid), 64'd0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
